// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared moduli and count-mode constants for the alarm clock digits
package clock_pkg;

  localparam int SEC_MOD   = 60;
  localparam int MIN_MOD   = 60;
  localparam int HR24_MOD  = 24;
  localparam int HR12_MOD  = 12;
  localparam int DIGIT_MOD = 10;
  localparam int TENS_MOD  = 6;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N up/down digit counter with load, cascade carry/borrow, wrap or saturate
module mod_counter
  import clock_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = DIGIT_MOD,
  parameter int RESET_VALUE = 0,
  parameter int SATURATE    = CNT_WRAP
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             LD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             Up,
  input  logic             Down,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] COUNT,
  output logic             CarryOut,
  output logic             BorrowOut,
  output logic             LoadErr
);

  if (MODULUS < 2) begin : g_bad_modulus
    $fatal(1, "mod_counter: MODULUS must be at least 2");
  end
  if (WIDTH < 1 || WIDTH > 30 || (2 ** WIDTH) < MODULUS) begin : g_bad_width
    $fatal(1, "mod_counter: WIDTH too small to hold MODULUS-1");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
    $fatal(1, "mod_counter: RESET_VALUE must lie in 0..MODULUS-1");
  end

  // One extra bit so count+1 at all-ones and 0-1 both stay distinguishable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic             SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] count_q, count_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH:0] up_ext;
  logic [WIDTH:0] dn_ext;
  logic           step;
  logic           do_load;
  logic           at_max;
  logic           at_zero;
  logic           load_bad;

  always_comb begin
    up_ext   = {1'b0, count_q} + ONE_EXT;
    dn_ext   = {1'b0, count_q} - ONE_EXT;
    at_max   = (up_ext == MOD_EXT);
    at_zero  = dn_ext[WIDTH];
    load_bad = ({1'b0, LOAD_VAL} >= MOD_EXT);
    step     = Enable & CarryIn & (Up ^ Down);
    do_load  = LD & Enable;

    count_d    = count_q;
    load_err_d = 1'b0;

    if (do_load) begin
      count_d    = load_bad ? MAX_VAL : LOAD_VAL;
      load_err_d = load_bad;
    end else if (step && Up) begin
      if (at_max) count_d = SAT ? MAX_VAL : '0;
      else        count_d = up_ext[WIDTH-1:0];
    end else if (step && Down) begin
      if (at_zero) count_d = SAT ? '0 : MAX_VAL;
      else         count_d = dn_ext[WIDTH-1:0];
    end
  end

  // Combinational cascade outputs: the next stage steps on the same edge.
  always_comb begin
    CarryOut  = 1'b0;
    BorrowOut = 1'b0;
    if (!do_load && !SAT) begin
      CarryOut  = step & Up & at_max;
      BorrowOut = step & Down & at_zero;
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      count_q    <= RST_VAL;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  assign COUNT   = count_q;
  assign LoadErr = load_err_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench: units(mod10) -> tens(mod6) chain plus a saturating mod10
module tb_mod_counter;

  logic       Clk;
  logic       Clr;
  logic       Enable, LD, Up, Down, CarryIn, LD_t;
  logic [3:0] LOAD_VAL, LOAD_VAL_t;
  logic [3:0] u_count, t_count, s_count;
  logic       u_co, u_bo, u_err, t_co, t_bo, t_err, s_co, s_bo, s_err;

  mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0), .SATURATE(0)) u_units (
    .Clk(Clk), .Clr(Clr), .Enable(Enable), .LD(LD), .LOAD_VAL(LOAD_VAL), .Up(Up), .Down(Down),
    .CarryIn(CarryIn), .COUNT(u_count), .CarryOut(u_co), .BorrowOut(u_bo), .LoadErr(u_err));

  mod_counter #(.WIDTH(4), .MODULUS(6), .RESET_VALUE(3), .SATURATE(0)) u_tens (
    .Clk(Clk), .Clr(Clr), .Enable(Enable), .LD(LD_t), .LOAD_VAL(LOAD_VAL_t), .Up(Up), .Down(Down),
    .CarryIn(u_co | u_bo), .COUNT(t_count), .CarryOut(t_co), .BorrowOut(t_bo), .LoadErr(t_err));

  mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(7), .SATURATE(1)) u_sat (
    .Clk(Clk), .Clr(Clr), .Enable(Enable), .LD(LD), .LOAD_VAL(LOAD_VAL), .Up(Up), .Down(Down),
    .CarryIn(CarryIn), .COUNT(s_count), .CarryOut(s_co), .BorrowOut(s_bo), .LoadErr(s_err));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string tag;
    int    cnt [3];
    bit    err [3];
    bit    co  [3];
    bit    bo  [3];
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: index 0 units, 1 tens, 2 saturating.
  int m_mod [3] = '{10, 6, 10};
  bit m_sat [3] = '{0, 0, 1};
  int m_rst [3] = '{0, 3, 7};
  int m_cnt [3];
  bit m_err [3];

  function automatic void check(input string name, input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%s]: got %0d expected %0d", name, tag, act, exp);
    end
  endfunction

  function automatic void model(input int i, input bit en, input bit ld, input int lv, input bit up,
                                input bit dn, input bit cin, output bit co, output bit bo,
                                output int nc, output bit nerr);
    bit stp;
    stp  = en && cin && (up != dn);
    co   = 0;
    bo   = 0;
    nerr = 0;
    nc   = m_cnt[i];
    if (ld && en) begin
      nerr = (lv >= m_mod[i]);
      nc   = nerr ? m_mod[i] - 1 : lv;
    end else if (stp && up) begin
      if (m_cnt[i] == m_mod[i] - 1) begin
        co = !m_sat[i];
        nc = m_sat[i] ? m_cnt[i] : 0;
      end else nc = m_cnt[i] + 1;
    end else if (stp && dn) begin
      if (m_cnt[i] == 0) begin
        bo = !m_sat[i];
        nc = m_sat[i] ? 0 : m_mod[i] - 1;
      end else nc = m_cnt[i] - 1;
    end
  endfunction

  function automatic void push_reset(input string tag);
    exp_t e;
    e.tag = tag;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = m_rst[i];
      m_err[i] = 0;
      e.cnt[i] = m_rst[i];
      e.err[i] = 0;
      e.co[i]  = 0;
      e.bo[i]  = 0;
    end
    sbq.push_back(e);
  endfunction

  task automatic drive(input bit en, input bit ld, input int lv, input bit up, input bit dn,
                       input bit cin, input bit ld_t, input int lv_t, input string tag);
    exp_t e;
    bit   co [3];
    bit   bo [3];
    int   nc [3];
    bit   ne [3];
    @(posedge Clk);
    #1;
    Enable = en; LD = ld; LOAD_VAL = 4'(lv); Up = up; Down = dn; CarryIn = cin;
    LD_t = ld_t; LOAD_VAL_t = 4'(lv_t);
    model(0, en, ld, lv, up, dn, cin, co[0], bo[0], nc[0], ne[0]);
    model(1, en, ld_t, lv_t, up, dn, co[0] | bo[0], co[1], bo[1], nc[1], ne[1]);
    model(2, en, ld, lv, up, dn, cin, co[2], bo[2], nc[2], ne[2]);
    e.tag = tag;
    for (int i = 0; i < 3; i++) begin
      e.cnt[i] = m_cnt[i];
      e.err[i] = m_err[i];
      e.co[i]  = co[i];
      e.bo[i]  = bo[i];
      m_cnt[i] = nc[i];
      m_err[i] = ne[i];
    end
    sbq.push_back(e);
  endtask

  task automatic clr_pulse();
    @(posedge Clk);
    #1;
    Enable = 0; LD = 0; LD_t = 0; Up = 0; Down = 0;
    Clr = 0;
    push_reset("clr_mid_cycle");
    @(negedge Clk);
    #1;
    Clr = 1;
  endtask

  // Monitor: compares whatever the DUTs present at each falling edge.
  initial begin
    forever begin
      exp_t e;
      int   ac [3];
      bit   ae [3];
      bit   ao [3];
      bit   ab [3];
      @(negedge Clk);
      if (sbq.size() > 0) begin
        e  = sbq.pop_front();
        ac = '{int'(u_count), int'(t_count), int'(s_count)};
        ae = '{u_err, t_err, s_err};
        ao = '{u_co, t_co, s_co};
        ab = '{u_bo, t_bo, s_bo};
        for (int i = 0; i < 3; i++) begin
          check($sformatf("count%0d", i), e.tag, ac[i], e.cnt[i]);
          check($sformatf("loaderr%0d", i), e.tag, int'(ae[i]), int'(e.err[i]));
          check($sformatf("carry%0d", i), e.tag, int'(ao[i]), int'(e.co[i]));
          check($sformatf("borrow%0d", i), e.tag, int'(ab[i]), int'(e.bo[i]));
        end
      end
    end
  end

  initial begin
    int guard;
    Clr = 0; Enable = 0; LD = 0; LOAD_VAL = 0; Up = 0; Down = 0; CarryIn = 1;
    LD_t = 0; LOAD_VAL_t = 0;
    #1;
    push_reset("reset");
    #11;
    Clr = 1;

    drive(1, 1, 8, 0, 0, 1, 0, 0, "load8");
    repeat (3) drive(1, 0, 0, 1, 0, 1, 0, 0, "up_wrap");
    drive(1, 1, 0, 0, 0, 1, 0, 0, "load0");
    drive(1, 0, 0, 0, 1, 1, 0, 0, "down_borrow");
    drive(1, 1, 9, 0, 0, 1, 0, 0, "load9");
    repeat (2) drive(1, 0, 0, 1, 0, 1, 0, 0, "sat_up");
    drive(1, 1, 12, 0, 0, 1, 0, 0, "load_clamp");
    drive(1, 1, 5, 0, 0, 1, 0, 0, "load5");
    drive(1, 0, 0, 0, 0, 1, 0, 0, "idle");
    drive(1, 1, 3, 1, 0, 1, 0, 0, "load_over_up");
    drive(1, 0, 0, 1, 1, 1, 0, 0, "up_and_down");
    drive(0, 1, 12, 1, 0, 1, 1, 9, "disabled");
    drive(1, 0, 0, 1, 0, 0, 0, 0, "no_carry_in");
    drive(1, 0, 0, 0, 0, 1, 0, 0, "idle");
    drive(1, 1, 9, 0, 0, 1, 1, 5, "cascade_load");
    drive(1, 0, 0, 1, 0, 1, 0, 0, "cascade_up");
    drive(1, 0, 0, 0, 1, 1, 0, 0, "cascade_down");
    drive(1, 0, 0, 0, 0, 1, 1, 7, "tens_clamp");
    drive(1, 0, 0, 1, 0, 1, 0, 0, "up_before_clr");
    drive(1, 0, 0, 0, 0, 1, 0, 0, "idle");
    clr_pulse();
    drive(1, 0, 0, 0, 0, 1, 0, 0, "after_clr");

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 15),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 6) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 15), "random");
      if (n % 97 == 50) clr_pulse();
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 10) begin
      @(negedge Clk);
      guard++;
    end
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter with synchronous load, count enable, cascade carry/borrow, and selectable wrap or saturate behaviour. It generalises the fixed 2-bit wrap-only digit counter. It is the building block for every time-keeping digit in the alarm clock: seconds/minutes units (mod 10), tens (mod 6), hours (mod 12/24), and the alarm-set digits. Instances chain through `CarryOut`/`BorrowOut` into the next digit's `CarryIn`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits. `2**WIDTH >= MODULUS` is required.
- `MODULUS`, default 10: count range is 0..MODULUS-1. Must be ≥ 2.
- `RESET_VALUE`, default 0: value forced by `Clr`. Must be < MODULUS.
- `SATURATE`, default 0: 0 wraps at the range limits; 1 holds at 0 or MODULUS-1.

Ports:
- `Clk` in 1: clock, rising-edge active.
- `Clr` in 1: asynchronous, active-low reset.
- `Enable` in 1: global qualifier for load and count.
- `LD` in 1: synchronous load request.
- `LOAD_VAL` in WIDTH: value to load.
- `Up` in 1: count-up request.
- `Down` in 1: count-down request.
- `CarryIn` in 1: cascade qualifier from the previous stage. Tie to 1 on the first stage.
- `COUNT` out WIDTH: current count, registered.
- `CarryOut` out 1: combinational. Set when a count-up step from MODULUS-1 happens this cycle.
- `BorrowOut` out 1: combinational. Set when a count-down step from 0 happens this cycle.
- `LoadErr` out 1: registered one-cycle pulse. Set when a load value was out of range.

## Operation
- `step = Enable & CarryIn & (Up ^ Down)`. If `Up` and `Down` are both high, the counter holds.
- Priority per rising edge: `Clr` low, then `LD & Enable`, then `step`, then hold.
- `Clr` low, at any time: `COUNT = RESET_VALUE` and `LoadErr = 0`, immediately and asynchronously. The count stays held until the first rising edge after release.
- Load:
  - If `LOAD_VAL < MODULUS`: `COUNT <= LOAD_VAL` and `LoadErr <= 0`.
  - Otherwise: `COUNT <= MODULUS-1` (clamped) and `LoadErr <= 1`.
  - Load ignores `CarryIn`, `Up` and `Down`.
- Up step:
  - If `COUNT == MODULUS-1`: next value is 0 when `SATURATE=0`, or MODULUS-1 when `SATURATE=1`.
  - Otherwise: `COUNT + 1`.
- Down step:
  - If `COUNT == 0`: next value is MODULUS-1 when `SATURATE=0`, or 0 when `SATURATE=1`.
  - Otherwise: `COUNT - 1`.
- `CarryOut = step & Up & (COUNT == MODULUS-1) & !SATURATE`. It is suppressed during a load cycle.
- `BorrowOut = step & Down & (COUNT == 0) & !SATURATE`. It is suppressed during a load cycle.
- `LoadErr` clears on the next edge that does not perform a faulty load.
- Arithmetic: next-value computation is WIDTH+1 bits wide, so `COUNT + 1` at `2**WIDTH - 1` cannot alias. `COUNT` never leaves 0..MODULUS-1 after reset.

## Timing
- Reset values: `COUNT = RESET_VALUE`, `LoadErr = 0`. `CarryOut` and `BorrowOut` follow their equations and are 0 whenever `Enable` is 0.
- Load and step latency: 1 clock. The new `COUNT` is visible after the edge.
- `CarryOut`/`BorrowOut` are valid in the same cycle as the wrapping step, before the edge. The next stage counts on that same edge, so the whole chain ripples within one cycle.
- Cascade depth is limited by the combinational carry path. Up to 6 stages is required at the system clock.
- If `Clr` is asserted in the same cycle as `LD` or a step, `Clr` wins. No partial update is allowed.
- An out-of-range `LOAD_VAL` with `Enable = 0` is ignored, and no `LoadErr` is raised.

## Structure
- Shared package `clock_pkg`:
  - Modulus constants: `SEC_MOD`=60, `MIN_MOD`=60, `HR24_MOD`=24, `HR12_MOD`=12, `DIGIT_MOD`=10, `TENS_MOD`=6.
  - Mode constants: `CNT_WRAP`=0, `CNT_SAT`=1.
- Single module. No sub-module is natural; the next-value logic is one combinational block.
- Parameter legality is checked at elaboration: illegal `MODULUS`, `RESET_VALUE` or `WIDTH` stops elaboration with a fatal message.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless stated.
- Up wrap: load 8, `Up` for 3 cycles → COUNT 9, 0, 1. `CarryOut` is 1 only in the cycle where COUNT=9 is stepped.
- Down wrap and borrow: load 0, `Down` for 1 cycle → COUNT=9, with `BorrowOut`=1 in the stepping cycle.
- Saturate (SATURATE=1): load 9, `Up` for 2 cycles → COUNT stays 9, `CarryOut` stays 0. Load 0, `Down` → COUNT stays 0.
- Load clamp: `LD` with `LOAD_VAL`=12 → COUNT=9 and `LoadErr`=1 for exactly one cycle. Then `LD` with 5 → COUNT=5 and `LoadErr`=0.
- Priority and holds:
  - `LD` and `Up` together with `LOAD_VAL`=3 → COUNT=3.
  - `Up` and `Down` together → hold.
  - `Enable`=0 → hold, no carry.
  - `CarryIn`=0 → hold.
- Async reset and cascade:
  - Mod-10 into mod-6 chain at 5:9 (tens:units), one `Up` → 0:0, and the tens stage raises `CarryOut`.
  - Pulse `Clr` low mid-cycle → both stages return to `RESET_VALUE` before the next edge.
